// File: rtl/serial_adder.sv
// Bit-serial N-bit adder: one full-adder stage reused LSB first, carry held in a register.
// Latency: start accepted at edge k -> done pulse after edge k+N (N+1 cycles start to done).
// Backpressure: start is taken only while busy is low; start during RUN is dropped, not queued.
module serial_adder #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a_in,
    input  logic [N-1:0] b_in,
    input  logic         cin,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] sum,
    output logic         cout
);

    localparam int CW = $clog2(N) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state;
    logic [N-1:0]   a_sh;
    logic [N-1:0]   b_sh;
    logic [N-1:0]   r_sh;
    logic           carry;
    logic [CW-1:0]  count;

    // y[1] is the carry, y[0] the sum bit of the current position.
    logic [1:0]     y;
    logic [N:0]     r_cat;

    assign y     = {1'b0, a_sh[0]} + {1'b0, b_sh[0]} + {1'b0, carry};
    assign r_cat = {y[0], r_sh};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            a_sh  <= '0;
            b_sh  <= '0;
            r_sh  <= '0;
            carry <= 1'b0;
            count <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sh  <= a_in;
                        b_sh  <= b_in;
                        carry <= cin;
                        count <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                RUN: begin
                    r_sh  <= r_cat[N:1];
                    carry <= y[1];
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    count <= count + CW'(1);
                    // Last bit: publish the fully shifted result together with the final carry.
                    if (count == CW'(N - 1)) begin
                        sum   <= r_cat[N:1];
                        cout  <= y[1];
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Randomized and directed checks of serial_adder (N=8 and N=1) against an arithmetic reference.
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       start = 1'b0;
    logic [7:0] a_in = '0, b_in = '0;
    logic       cin = 1'b0;
    logic       busy, done, cout;
    logic [7:0] sum;

    logic       start1 = 1'b0;
    logic       a1 = 1'b0, b1 = 1'b0, c1 = 1'b0;
    logic       busy1, done1, cout1;
    logic       sum1;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    serial_adder #(.N(8)) dut (
        .clk(clk), .rst(rst), .start(start), .a_in(a_in), .b_in(b_in), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout)
    );

    serial_adder #(.N(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a_in(a1), .b_in(b1), .cin(c1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one addition on the N=8 instance and check result, latency, busy span and single done pulse.
    // poke >= 0 drives a stray start with junk operands at that cycle of RUN.
    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic c, input int poke);
        int unsigned exp;
        int          lat;
        int          busy_cnt;
        logic [7:0]  prev_sum;
        logic        prev_cout;
        logic        held;
        exp       = int'(a) + int'(b) + int'(c);
        prev_sum  = sum;
        prev_cout = cout;
        held      = 1'b1;
        a_in = a; b_in = b; cin = c; start = 1'b1;
        tick();
        start = 1'b0;
        a_in = 8'($urandom); b_in = 8'($urandom); cin = 1'($urandom);
        lat = 0;
        busy_cnt = 0;
        while (!done && lat < 40) begin
            if (busy) busy_cnt++;
            if (sum !== prev_sum || cout !== prev_cout) held = 1'b0;
            start = (lat == poke);
            if (lat == poke) begin
                a_in = 8'hAA; b_in = 8'h55;
            end
            tick();
            start = 1'b0;
            lat++;
        end
        check({tag, ".latency"}, 32'(lat), 32'd8);
        check({tag, ".busy_cycles"}, 32'(busy_cnt), 32'd8);
        check({tag, ".held"}, 32'(held), 32'd1);
        check({tag, ".sum"}, 32'(sum), exp & 32'hFF);
        check({tag, ".cout"}, 32'(cout), (exp >> 8) & 32'h1);
        check({tag, ".busy_at_done"}, 32'(busy), 32'd0);
        tick();
        check({tag, ".done_single"}, 32'(done), 32'd0);
        check({tag, ".idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int lat;
        int unsigned exp;
        #1;
        check("reset.busy", 32'(busy), 32'd0);
        check("reset.done", 32'(done), 32'd0);
        check("reset.sum", 32'(sum), 32'd0);
        check("reset.cout", 32'(cout), 32'd0);
        check("reset1.sumcout", 32'({cout1, sum1, busy1, done1}), 32'd0);
        tick();
        rst = 1'b0;
        tick();

        run_op("basic", 8'h3C, 8'h5A, 1'b0, -1);
        run_op("ovf", 8'hFF, 8'h01, 1'b0, -1);
        run_op("max", 8'hFF, 8'hFF, 1'b1, -1);
        run_op("ignore", 8'h10, 8'h20, 1'b0, 2);

        // Back-to-back with start held high; operands change in the DONE cycle.
        a_in = 8'h01; b_in = 8'h01; cin = 1'b0; start = 1'b1;
        tick();
        lat = 0;
        while (!done && lat < 40) begin tick(); lat++; end
        check("b2b.first_lat", 32'(lat), 32'd8);
        check("b2b.first_sum", 32'({cout, sum}), 32'h002);
        a_in = 8'h80; b_in = 8'h80;
        tick();
        lat = 1;
        while (!done && lat < 40) begin tick(); lat++; end
        check("b2b.spacing", 32'(lat), 32'd9);
        check("b2b.second_sum", 32'({cout, sum}), 32'h100);
        start = 1'b0;
        tick();
        check("b2b.idle", 32'({busy, done}), 32'd0);

        // Asynchronous reset in the middle of RUN.
        a_in = 8'h7F; b_in = 8'h01; cin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        check("abort.busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check("abort.outputs", 32'({busy, done, cout, sum}), 32'd0);
        tick();
        rst = 1'b0;
        lat = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done || busy) lat++;
        end
        check("abort.no_done", 32'(lat), 32'd0);
        run_op("after_abort", 8'h05, 8'h03, 1'b0, -1);

        for (int i = 0; i < 20; i++)
            run_op("rand", 8'($urandom), 8'($urandom), 1'($urandom),
                   ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : -1);

        // N=1: exhaustive over a, b, cin.
        for (int v = 0; v < 8; v++) begin
            a1 = v[2]; b1 = v[1]; c1 = v[0]; start1 = 1'b1;
            exp = int'(v[2]) + int'(v[1]) + int'(v[0]);
            tick();
            start1 = 1'b0;
            check("n1.busy", 32'(busy1), 32'd1);
            lat = 0;
            while (!done1 && lat < 10) begin tick(); lat++; end
            check("n1.latency", 32'(lat), 32'd1);
            check("n1.result", 32'({cout1, sum1}), exp);
            tick();
            check("n1.done_single", 32'(done1), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial N-bit adder built around the 3-input, 2-bit-output full-adder stage (y = a + b + c, y[1] = carry, y[0] = sum).
- Consumes that stage's output every clock: registers y[1] as the next carry-in and shifts y[0] into a result register, LSB first.
- Sits downstream of the full adder in the arithmetic datapath and presents a start/busy/done handshake to the controller.

Parameters:
- N, default 8: operand and result width in bits; legal range 1 to 32.

Ports:
- clk  input  1  system clock, rising-edge active
- rst  input  1  asynchronous, active-high reset
- start  input  1  request a new addition; sampled on the rising clk edge
- a_in  input  N  operand A; captured when start is accepted
- b_in  input  N  operand B; captured when start is accepted
- cin  input  1  carry-in; captured when start is accepted
- busy  output  1  high while an addition is in progress
- done  output  1  single-cycle pulse when sum and cout are updated
- sum  output  N  registered result
- cout  output  1  registered final carry-out

Behaviour:
- One clock domain, clk. Reset is asynchronous and active-high.
- Reset values: state = IDLE; busy = 0; done = 0; sum = 0; cout = 0. All internal shift registers, the carry register and the bit counter are cleared.
- States:
  - IDLE: waiting for start.
  - RUN: processes one bit per cycle.
  - DONE: one cycle long; done = 1.
- Start acceptance:
  - start is accepted only in IDLE or DONE, i.e. when busy = 0.
  - On acceptance: A_sh <= a_in, B_sh <= b_in, carry <= cin, count <= 0, state <= RUN.
  - start in RUN is ignored. It is not queued and operands are not recaptured.
- RUN cycle:
  - The full-adder inputs are A_sh[0], B_sh[0] and carry.
  - Updates: R_sh <= {y[0], R_sh[N-1:1]}; carry <= y[1]; A_sh and B_sh shift right by 1 with zero fill; count <= count + 1.
  - When count = N-1 at the edge: sum <= {y[0], R_sh[N-1:1]}, cout <= y[1], state <= DONE.
- DONE:
  - done = 1 for exactly one cycle.
  - Next state is RUN if start = 1, otherwise IDLE.
- busy = 1 only in RUN. It is a registered output, high from the edge after acceptance until the edge that enters DONE.
- Latency: start accepted at edge k gives done high in the cycle following edge k+N. The total is N+1 cycles from start to done.
- Back-to-back: start held high continuously yields one result every N+1 cycles.
- sum and cout change only on the edge entering DONE. They hold their previous values throughout RUN and IDLE, so the controller can read them at any time.
- Arithmetic is modulo 2^N, with the overflow carry reported on cout. {cout, sum} = a_in + b_in + cin exactly, as an N+1-bit result.
- Counter width is clog2(N)+1 bits. For N = 1, RUN lasts exactly one cycle.
- Reset mid-operation: asserting rst during RUN or DONE immediately aborts. Outputs return to their reset values with no done pulse, and the next operation requires a fresh start.
- Operands on a_in, b_in and cin may change freely after acceptance with no effect on the result in progress.
- No X propagation: every register has a defined reset value.

Test Plan:
- Reset, then start with a_in=0x3C, b_in=0x5A, cin=0 (N=8): busy high for 8 cycles, done pulses at cycle 9, sum=0x96, cout=0.
- a_in=0xFF, b_in=0x01, cin=0: sum=0x00, cout=1. Then a_in=0xFF, b_in=0xFF, cin=1: sum=0xFF, cout=1.
- Start with 0x10+0x20, then pulse start again with 0xAA+0x55 during RUN cycle 3: second request ignored, result sum=0x30, cout=0, exactly one done pulse.
- Hold start high with 0x01+0x01, changing to 0x80+0x80 in the DONE cycle: results 0x02/cout=0, then 0x00/cout=1, with done pulses exactly 9 cycles apart.
- Start 0x7F+0x01, assert rst for 1 cycle at RUN cycle 4: busy=0, done=0, sum=0x00, cout=0 immediately. A new start with 0x05+0x03 gives sum=0x08.
- N=1 build, all 8 combinations of a_in, b_in and cin: {cout, sum} equals a+b+c for each, i.e. 0,1,1,1,2,2,2,3, with done 2 cycles after each start.
